// File: rtl/video_capture.sv
// Video capture front end: samples an external dotclk/hsync/vsync/RGB link with a fast system clock,
// measures frame and line totals, and emits one pix_valid pulse per active-area pixel.
module video_capture #(
  parameter int unsigned H_ACTIVE = 240,
  parameter int unsigned V_ACTIVE = 320,
  parameter int unsigned H_BP     = 20,
  parameter int unsigned V_BP     = 4,
  parameter int unsigned H_BITS   = 10,
  parameter int unsigned V_BITS   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dotclk,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic              pix_valid,
  output logic [H_BITS-1:0] pix_x,
  output logic [V_BITS-1:0] pix_y,
  output logic [23:0]       pix_rgb,
  output logic              frame_start,
  output logic              locked,
  output logic [V_BITS:0]   lines_per_frame,
  output logic [H_BITS:0]   dots_per_line,
  output logic              timeout_err
);

  localparam logic [H_BITS-1:0] HMax = '1;
  localparam logic [V_BITS-1:0] VMax = '1;
  localparam int unsigned       HEnd = H_BP + H_ACTIVE;
  localparam int unsigned       VEnd = V_BP + V_ACTIVE;

  typedef enum logic {StIdle, StCapture} state_e;

  // {dotclk, hsync, vsync, red, green, blue} share one synchronizer so they stay aligned
  logic [26:0] sync1_q, sync2_q;
  logic        dot_s, hs_s, vs_s;
  logic [23:0] rgb_s;

  state_e            state_q, state_d;
  logic              dot_prev_q;
  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              seen_h_q, seen_h_d;
  logic [H_BITS-1:0] h_cnt_q, h_cnt_d;
  logic [V_BITS-1:0] v_cnt_q, v_cnt_d;
  logic              pix_valid_d, frame_start_d, locked_d, timeout_err_d;
  logic [H_BITS-1:0] pix_x_d;
  logic [V_BITS-1:0] pix_y_d;
  logic [23:0]       pix_rgb_d;
  logic [V_BITS:0]   lines_per_frame_d, lines_new;
  logic [H_BITS:0]   dots_per_line_d;
  logic              dot_rise, hs_fall, vs_fall, run, active;

  // Two-flop synchronizer for the whole video link
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {dotclk, hsync, vsync, red, green, blue};
      sync2_q <= sync1_q;
    end
  end

  assign dot_s = sync2_q[26];
  assign hs_s  = sync2_q[25];
  assign vs_s  = sync2_q[24];
  assign rgb_s = sync2_q[23:0];

  assign dot_rise = dot_s & ~dot_prev_q;
  assign hs_fall  = dot_rise & hs_prev_q & ~hs_s;
  assign vs_fall  = dot_rise & vs_prev_q & ~vs_s;
  // The vsync fall that leaves IDLE already counts as a capture dot
  assign run      = dot_rise & ((state_q == StCapture) | vs_fall);

  // Next-state: counters, measurements, lock tracking and pixel output
  always_comb begin
    state_d           = state_q;
    hs_prev_d         = hs_prev_q;
    vs_prev_d         = vs_prev_q;
    seen_h_d          = seen_h_q;
    h_cnt_d           = h_cnt_q;
    v_cnt_d           = v_cnt_q;
    pix_valid_d       = 1'b0;
    frame_start_d     = 1'b0;
    pix_x_d           = pix_x;
    pix_y_d           = pix_y;
    pix_rgb_d         = pix_rgb;
    locked_d          = locked;
    lines_per_frame_d = lines_per_frame;
    dots_per_line_d   = dots_per_line;
    timeout_err_d     = timeout_err;
    lines_new         = (V_BITS+1)'(v_cnt_q) + (V_BITS+1)'(1);
    active            = 1'b0;

    if (dot_rise) begin
      hs_prev_d = hs_s;
      vs_prev_d = vs_s;
    end

    if ((state_q == StIdle) && vs_fall) begin
      state_d = StCapture;
    end

    if (run) begin
      if (hs_fall) begin
        h_cnt_d  = '0;
        seen_h_d = 1'b1;
        // First hsync fall after IDLE ends a partial line; don't report it
        if (seen_h_q) begin
          dots_per_line_d = (H_BITS+1)'(h_cnt_q) + (H_BITS+1)'(1);
        end
      end else if (h_cnt_q != HMax) begin
        h_cnt_d = h_cnt_q + H_BITS'(1);
      end

      if (vs_fall) begin
        v_cnt_d = '0;
      end else if (hs_fall && (v_cnt_q != VMax)) begin
        v_cnt_d = v_cnt_q + V_BITS'(1);
      end

      if (vs_fall && (state_q == StCapture)) begin
        lines_per_frame_d = lines_new;
        locked_d          = (lines_new == lines_per_frame) && (lines_new != '0);
      end

      if (h_cnt_d == HMax) begin
        timeout_err_d = 1'b1;
      end

      active = (32'(h_cnt_d) >= H_BP) && (32'(h_cnt_d) < HEnd) &&
               (32'(v_cnt_d) >= V_BP) && (32'(v_cnt_d) < VEnd);
      if (active) begin
        pix_valid_d   = 1'b1;
        pix_x_d       = h_cnt_d - H_BITS'(H_BP);
        pix_y_d       = v_cnt_d - V_BITS'(V_BP);
        pix_rgb_d     = rgb_s;
        frame_start_d = (pix_x_d == '0) && (pix_y_d == '0);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      dot_prev_q      <= 1'b0;
      hs_prev_q       <= 1'b0;
      vs_prev_q       <= 1'b0;
      seen_h_q        <= 1'b0;
      h_cnt_q         <= '0;
      v_cnt_q         <= '0;
      pix_valid       <= 1'b0;
      pix_x           <= '0;
      pix_y           <= '0;
      pix_rgb         <= '0;
      frame_start     <= 1'b0;
      locked          <= 1'b0;
      lines_per_frame <= '0;
      dots_per_line   <= '0;
      timeout_err     <= 1'b0;
    end else begin
      state_q         <= state_d;
      dot_prev_q      <= dot_s;
      hs_prev_q       <= hs_prev_d;
      vs_prev_q       <= vs_prev_d;
      seen_h_q        <= seen_h_d;
      h_cnt_q         <= h_cnt_d;
      v_cnt_q         <= v_cnt_d;
      pix_valid       <= pix_valid_d;
      pix_x           <= pix_x_d;
      pix_y           <= pix_y_d;
      pix_rgb         <= pix_rgb_d;
      frame_start     <= frame_start_d;
      locked          <= locked_d;
      lines_per_frame <= lines_per_frame_d;
      dots_per_line   <= dots_per_line_d;
      timeout_err     <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a shrunken geometry: 30-dot lines, 8x4 active area
// starting at dot 20 / line 4, 6-bit h counter (saturates at 63), clk = 4x dotclk.
module tb_video_capture;

  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;
  localparam int unsigned HB = 20;
  localparam int unsigned VB = 4;
  localparam int unsigned HW = 6;
  localparam int unsigned VW = 5;
  localparam int          NDOTS = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dotclk = 1'b0;
  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic [7:0]    red = '0, green = '0, blue = '0;
  logic          pix_valid, frame_start, locked, timeout_err;
  logic [HW-1:0] pix_x;
  logic [VW-1:0] pix_y;
  logic [23:0]   pix_rgb;
  logic [VW:0]   lines_per_frame;
  logic [HW:0]   dots_per_line;

  int total = 0;
  int bad = 0;

  int            pix_cnt = 0;
  bit            first_pending = 1'b0;
  logic [HW-1:0] first_x, last_x;
  logic [VW-1:0] first_y, last_y;
  logic          first_fs;

  video_capture #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BP(HB), .V_BP(VB), .H_BITS(HW), .V_BITS(VW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dotclk         (dotclk),
    .hsync          (hsync),
    .vsync          (vsync),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .pix_valid      (pix_valid),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_rgb        (pix_rgb),
    .frame_start    (frame_start),
    .locked         (locked),
    .lines_per_frame(lines_per_frame),
    .dots_per_line  (dots_per_line),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel monitor: data was driven as {x, y, 0x80}, so each pulse must agree with its coordinates
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      pix_cnt++;
      check("pix_rgb", 32'(pix_rgb), 32'({2'b00, pix_x, 3'b000, pix_y, 8'h80}));
      check("frame_start", 32'(frame_start), 32'((pix_x == '0) && (pix_y == '0)));
      if (first_pending) begin
        first_pending = 1'b0;
        first_x  = pix_x;
        first_y  = pix_y;
        first_fs = frame_start;
      end
      last_x = pix_x;
      last_y = pix_y;
    end else begin
      check("fs_alone", 32'(frame_start), 32'(0));
    end
  end

  // One dot period: 2 clk low then 2 clk high; data changes only while dotclk is low
  task automatic dot(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g);
    dotclk = 1'b0;
    hsync  = hs;
    vsync  = vs;
    red    = r;
    green  = g;
    blue   = 8'h80;
    repeat (2) @(negedge clk);
    dotclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_pulse_check();
    rst = 1'b0;
    #1;
    check("rst pix_valid", 32'(pix_valid), 32'(0));
    check("rst pix_x", 32'(pix_x), 32'(0));
    check("rst pix_y", 32'(pix_y), 32'(0));
    check("rst pix_rgb", 32'(pix_rgb), 32'(0));
    check("rst frame_start", 32'(frame_start), 32'(0));
    check("rst locked", 32'(locked), 32'(0));
    check("rst lines", 32'(lines_per_frame), 32'(0));
    check("rst dots", 32'(dots_per_line), 32'(0));
    check("rst timeout", 32'(timeout_err), 32'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  // hsync low for dots 0-1, vsync low for lines 0-1; rst_at >= 0 pulses reset at that dot
  task automatic line(input int l, input int rst_at);
    for (int d = 0; d < NDOTS; d++) begin
      if (d == rst_at) reset_pulse_check();
      dot(d >= 2, l >= 2, 8'(d - int'(HB)), 8'(l - int'(VB)));
    end
  endtask

  task automatic frame(input int nl);
    for (int l = 0; l < nl; l++) line(l, -1);
  endtask

  initial begin
    int base;
    reset_pulse_check();
    repeat (4) dot(1'b1, 1'b1, 8'h00, 8'h00);
    check("idle no pixels", 32'(pix_cnt), 32'(0));

    // Frame A: IDLE exit on a same-dot vsync/hsync fall
    first_pending = 1'b1;
    frame(12);
    check("A pix count", 32'(pix_cnt), 32'(32));
    check("A first x", 32'(first_x), 32'(0));
    check("A first y", 32'(first_y), 32'(0));
    check("A first fs", 32'(first_fs), 32'(1));
    check("A last x", 32'(last_x), 32'(7));
    check("A last y", 32'(last_y), 32'(3));
    check("A hold x", 32'(pix_x), 32'(7));
    check("A hold y", 32'(pix_y), 32'(3));
    check("A dots", 32'(dots_per_line), 32'(30));
    check("A lines", 32'(lines_per_frame), 32'(0));
    check("A locked", 32'(locked), 32'(0));

    frame(12);
    check("B pix count", 32'(pix_cnt), 32'(64));
    check("B lines", 32'(lines_per_frame), 32'(12));
    check("B locked", 32'(locked), 32'(0));

    // Second equal measurement locks
    frame(14);
    check("C pix count", 32'(pix_cnt), 32'(96));
    check("C lines", 32'(lines_per_frame), 32'(12));
    check("C locked", 32'(locked), 32'(1));

    // The 14-line frame is measured here and breaks lock
    frame(12);
    check("D lines", 32'(lines_per_frame), 32'(14));
    check("D locked", 32'(locked), 32'(0));
    check("D dots", 32'(dots_per_line), 32'(30));
    check("D timeout", 32'(timeout_err), 32'(0));

    // Long line: h_cnt runs 29 -> 63 and saturates
    repeat (40) dot(1'b1, 1'b1, 8'h00, 8'h00);
    check("timeout set", 32'(timeout_err), 32'(1));

    frame(12);
    check("E timeout sticky", 32'(timeout_err), 32'(1));
    check("E dots", 32'(dots_per_line), 32'(30));
    check("E lines", 32'(lines_per_frame), 32'(12));
    check("E locked", 32'(locked), 32'(0));
    check("E pix count", 32'(pix_cnt), 32'(160));

    // Reset mid-line in the active area, then finish the frame: nothing captured
    for (int l = 0; l < 4; l++) line(l, -1);
    base = pix_cnt;
    line(4, 10);
    for (int l = 5; l < 12; l++) line(l, -1);
    check("F no capture", 32'(pix_cnt), 32'(base));
    check("F lines", 32'(lines_per_frame), 32'(0));
    check("F dots", 32'(dots_per_line), 32'(0));
    check("F timeout", 32'(timeout_err), 32'(0));
    check("F locked", 32'(locked), 32'(0));

    // Next vsync fall restarts capture at (0,0)
    first_pending = 1'b1;
    frame(12);
    check("G pix count", 32'(pix_cnt), 32'(base + 32));
    check("G first x", 32'(first_x), 32'(0));
    check("G first y", 32'(first_y), 32'(0));
    check("G first fs", 32'(first_fs), 32'(1));
    check("G last x", 32'(last_x), 32'(7));
    check("G last y", 32'(last_y), 32'(3));
    check("G dots", 32'(dots_per_line), 32'(30));
    check("G lines", 32'(lines_per_frame), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 240, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 320, active lines per frame.
REQ-003 SHALL have parameter H_BP, default 20, dotclk rising edges from hsync fall to first active pixel.
REQ-004 SHALL have parameter V_BP, default 4, hsync falls from vsync fall to first active line.
REQ-005 SHALL have parameters H_BITS, default 10, and V_BITS, default 10, counter widths.
REQ-006 SHALL have port clk  input  1  system clock, at least 4x dotclk frequency.
REQ-007 SHALL have port rst  input  1  reset; one clock; asynchronous, active-low.
REQ-008 SHALL have ports dotclk, hsync, vsync  input  1 each  video link; syncs active-low.
REQ-009 SHALL have ports red, green, blue  input  8 each  pixel data.
REQ-010 SHALL have port pix_valid  output  1  one-clk pulse per captured active pixel.
REQ-011 SHALL have ports pix_x  output  H_BITS, and pix_y  output  V_BITS  active-area coordinates.
REQ-012 SHALL have port pix_rgb  output  24  {red,green,blue} of captured pixel.
REQ-013 SHALL have port frame_start  output  1  high with pix_valid at (0,0) only.
REQ-014 SHALL have port locked  output  1  frame timing stable.
REQ-015 SHALL have ports lines_per_frame  output  V_BITS+1, and dots_per_line  output  H_BITS+1  last measured totals.
REQ-016 SHALL have port timeout_err  output  1  sticky; no hsync within 2^H_BITS-1 dots.

Function
REQ-017 SHALL pass dotclk, hsync, vsync, red, green, blue through identical 2-flop synchronizers; dot_rise = synced dotclk 1 now, 0 previous clk.
REQ-018 SHALL evaluate all timing and capture only on clk cycles where dot_rise is high; other cycles hold state.
REQ-019 SHALL detect hsync fall / vsync fall as sampled 0 on this dot_rise, 1 on previous dot_rise.
REQ-020 SHALL use states IDLE and CAPTURE; IDLE -> CAPTURE on first vsync fall; no return except reset.
REQ-021 In IDLE SHALL emit no pix_valid and count nothing.
REQ-022 h_cnt SHALL reset to 0 on hsync fall, else increment per dot_rise, saturating at 2^H_BITS-1.
REQ-023 On hsync fall SHALL load dots_per_line with h_cnt+1 (previous line total), except the first hsync fall after entering CAPTURE.
REQ-024 v_cnt SHALL reset to 0 on vsync fall, increment on each other hsync fall, saturating at 2^V_BITS-1.
REQ-025 Same-dot vsync fall and hsync fall SHALL give v_cnt=0, h_cnt=0.
REQ-026 On vsync fall SHALL load lines_per_frame with v_cnt+1, except the first vsync fall (IDLE exit).
REQ-027 A dot is active when H_BP <= h_cnt < H_BP+H_ACTIVE and V_BP <= v_cnt < V_BP+V_ACTIVE, counters taken after this dot's update.
REQ-028 For an active dot SHALL, on the clk after dot_rise, pulse pix_valid with pix_x=h_cnt-H_BP, pix_y=v_cnt-V_BP, pix_rgb=sampled data; latency 1 clk from dot_rise.
REQ-029 pix_x, pix_y, pix_rgb SHALL hold between pix_valid pulses.
REQ-030 locked SHALL set when two consecutive lines_per_frame loads are equal and nonzero; clear on any unequal load.
REQ-031 timeout_err SHALL set when h_cnt reaches saturation in CAPTURE; cleared only by reset.

Reset
REQ-032 On rst low, asynchronously: state IDLE, counters, synchronizers, pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, lines_per_frame, dots_per_line, timeout_err all 0.
REQ-033 Reset released mid-frame SHALL capture nothing until next vsync fall.

Verification
REQ-034 Defaults, clk=4x dotclk, full frame with 280-dot lines, 328-line frames, rgb={x,y,0x80} -> 76800 pix_valid; first pixel (0,0) with frame_start; last (239,319).
REQ-035 Two full frames -> lines_per_frame=328, dots_per_line=280; locked set at second measured vsync fall.
REQ-036 Third frame with 330 lines -> locked clears at its vsync fall; lines_per_frame=330.
REQ-037 hsync held high 1023 dots in CAPTURE -> timeout_err=1, stays 1 after hsync resumes.
REQ-038 rst low mid-line, released mid-frame -> all outputs 0, no pix_valid until next vsync fall, then capture from (0,0).
REQ-039 vsync and hsync fall same dot -> v_cnt=0, h_cnt=0; first active pixel at dot 20 of line 4.
